slave_out: RTL and testbench

Slave-side read-data transmitter. On a read request, it fetches bytes from the slave's local memory and serialises them MSB-first onto the 1-bit return line, supporting single and burst transfers. It drives `slave_valid`/`tx_data` directly into the master's receive stage (`MasterIn`), paced by `master_ready`.

---
 rtl/slave_out_pkg.sv | 28 ++
 rtl/slave_out_shift.sv | 43 ++++
 rtl/slave_out.sv | 152 +++++++++++++++
 tb/tb_slave_out.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_out_pkg.sv
// Shared types and constants for the slave read-data transmitter.
package slave_out_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0] INSTR_READ = 2'b11;
  localparam int BURST_W = 12;

  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // A burst count of zero still moves one byte.
  function automatic logic [BURST_W-1:0] beats_of(
    input logic [BURST_W-1:0] n
  );
    return (n == '0) ? BURST_W'(1) : n;
  endfunction

endpackage

// File: rtl/slave_out_shift.sv
// Parallel-in serial-out shift register with a per-byte bit counter.
module slave_out_shift
  import slave_out_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = cnt_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  q_msb,
  output logic                  q_nxt,
  output logic                  last,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] r_sh;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_sh  <= d;
      r_cnt <= '0;
    end else if (shift) begin
      r_sh  <= {r_sh[DATA_WIDTH-2:0], 1'b0};
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign q_msb = r_sh[DATA_WIDTH-1];
  assign q_nxt = r_sh[DATA_WIDTH-2];
  assign last  = w_last;
  assign cnt   = r_cnt;

endmodule

// File: rtl/slave_out.sv
// Slave-side read-data transmitter: fetches bytes from local memory
// and serialises them MSB-first onto the 1-bit return line.
module slave_out
  import slave_out_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            instruction,
  input  logic [BURST_W-1:0]    burst_num,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  master_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  tx_done,
  output logic                  busy
);

  localparam int CNT_W = cnt_w(DATA_WIDTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BURST_W-1:0]    r_beats;
  logic [DATA_WIDTH-1:0] r_nbuf;
  logic                  r_rd_en;
  logic                  r_valid;
  logic                  r_tx;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_load;
  logic                  w_shift;
  logic [DATA_WIDTH-1:0] w_load_d;
  logic                  w_q_msb;
  logic                  w_q_nxt;
  logic                  w_last;
  logic [CNT_W-1:0]      w_bit_cnt;
  logic                  w_more;
  logic                  w_pre;

  assign w_load   = (r_state == S_LOAD) ||
                    ((r_state == S_GAP) && master_ready);
  assign w_load_d = (r_state == S_LOAD) ? mem_rdata : r_nbuf;
  assign w_shift  = (r_state == S_SEND);
  assign w_more   = (r_beats > BURST_W'(1));
  // Strobe lands in the second-to-last bit so data is ready at the byte end.
  assign w_pre    = w_more &&
                    (w_bit_cnt == CNT_W'(DATA_WIDTH - 3));

  slave_out_shift #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (w_load),
    .shift(w_shift),
    .d    (w_load_d),
    .q_msb(w_q_msb),
    .q_nxt(w_q_nxt),
    .last (w_last),
    .cnt  (w_bit_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_addr  <= '0;
      r_beats <= '0;
      r_nbuf  <= '0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_tx    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && (instruction == INSTR_READ)) begin
            r_cur   <= base_addr;
            r_addr  <= base_addr;
            r_beats <= beats_of(burst_num);
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_cur   <= r_cur + ADDR_WIDTH'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (master_ready) begin
            r_valid <= 1'b1;
            r_tx    <= w_q_msb;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_last) begin
            r_beats <= r_beats - BURST_W'(1);
            r_tx    <= 1'b0;
            if (w_more) begin
              r_nbuf  <= mem_rdata;
              r_state <= S_GAP;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_tx <= w_q_nxt;
            if (w_pre) begin
              r_rd_en <= 1'b1;
              r_addr  <= r_cur;
            end
          end
        end
        S_GAP: begin
          if (master_ready) begin
            r_cur   <= r_cur + ADDR_WIDTH'(1);
            r_tx    <= r_nbuf[DATA_WIDTH-1];
            r_state <= S_SEND;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_addr;
  assign slave_valid = r_valid;
  assign tx_data     = r_tx;
  assign tx_done     = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_slave_out.sv
// Directed self-checking bench for slave_out with a synchronous
// memory model that logs every read strobe.
module tb_slave_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        master_ready;
  logic [1:0]  instruction;
  logic [11:0] burst_num;
  logic [11:0] base_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic        slave_valid;
  logic        tx_data;
  logic        tx_done;
  logic        busy;

  logic [7:0]  mem [0:4095];
  logic [11:0] rd_log [0:63];
  int          rd_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd0;
  logic [7:0]  b;
  logic        v;

  slave_out #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .burst_num   (burst_num),
    .base_addr   (base_addr),
    .master_ready(master_ready),
    .mem_rdata   (mem_rdata),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .slave_valid (slave_valid),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata              <= mem[mem_addr];
      rd_log[rd_cnt[5:0]]    <= mem_addr;
      rd_cnt                 <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [1:0] ins, input logic [11:0] a,
                    input logic [11:0] n);
    start       = 1'b1;
    instruction = ins;
    base_addr   = a;
    burst_num   = n;
    cyc(1);
    start = 1'b0;
  endtask

  // Collect 8 bits; optionally raise start for the edge after bit 'poke'.
  task automatic recv(output logic [7:0] bo, output logic vo,
                      input int poke);
    bo = '0;
    vo = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      bo = {bo[6:0], tx_data};
      vo = vo & slave_valid;
      start = (i == poke);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'hB5;
    mem[12'h020] = 8'h7A;
    mem[12'h021] = 8'h2B;
    mem[12'h022] = 8'h7B;
    mem[12'h030] = 8'hC3;
    mem[12'h031] = 8'h5E;
    mem[12'hFFF] = 8'h81;
    mem[12'h000] = 8'h3C;
    reset        = 1'b1;
    start        = 1'b0;
    master_ready = 1'b1;
    instruction  = 2'b00;
    burst_num    = '0;
    base_addr    = '0;
    #1;
    check("rst_valid", 32'(slave_valid), 32'd0);
    check("rst_tx", 32'(tx_data), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rden", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Single read, burst_num 0
    go(2'b11, 12'h010, 12'd0);
    check("s_busy", 32'(busy), 32'd1);
    check("s_rden", 32'(mem_rd_en), 32'd1);
    check("s_addr", 32'(mem_addr), 32'h010);
    cyc(1);
    check("s_rden_off", 32'(mem_rd_en), 32'd0);
    cyc(1);
    check("s_wait_valid", 32'(slave_valid), 32'd0);
    recv(b, v, -1);
    check("s_byte", 32'(b), 32'hB5);
    check("s_valid", 32'(v), 32'd1);
    cyc(1);
    check("s_done", 32'(tx_done), 32'd1);
    check("s_done_valid", 32'(slave_valid), 32'd0);
    check("s_done_busy", 32'(busy), 32'd1);
    cyc(1);
    check("s_done_off", 32'(tx_done), 32'd0);
    check("s_idle_busy", 32'(busy), 32'd0);

    // Burst of 3
    rd0 = rd_cnt;
    go(2'b11, 12'h020, 12'd3);
    cyc(2);
    recv(b, v, -1);
    check("b3_byte0", 32'(b), 32'h7A);
    cyc(1);
    check("b3_gap0_valid", 32'(slave_valid), 32'd1);
    check("b3_gap0_tx", 32'(tx_data), 32'd0);
    recv(b, v, -1);
    check("b3_byte1", 32'(b), 32'h2B);
    check("b3_valid1", 32'(v), 32'd1);
    cyc(1);
    check("b3_gap1_valid", 32'(slave_valid), 32'd1);
    check("b3_gap1_tx", 32'(tx_data), 32'd0);
    recv(b, v, -1);
    check("b3_byte2", 32'(b), 32'h7B);
    cyc(1);
    check("b3_done", 32'(tx_done), 32'd1);
    check("b3_reads", 32'(rd_cnt - rd0), 32'd3);
    check("b3_addr2", 32'(rd_log[6'(rd0 + 2)]), 32'h022);
    cyc(1);

    // Backpressure in WAIT and in the first GAP
    master_ready = 1'b0;
    go(2'b11, 12'h030, 12'd2);
    cyc(7);
    check("bp_wait_valid", 32'(slave_valid), 32'd0);
    check("bp_wait_busy", 32'(busy), 32'd1);
    master_ready = 1'b1;
    recv(b, v, -1);
    check("bp_byte0", 32'(b), 32'hC3);
    master_ready = 1'b0;
    cyc(1);
    check("bp_gap_a", 32'({slave_valid, tx_data}), 32'd2);
    cyc(1);
    check("bp_gap_b", 32'({slave_valid, tx_data}), 32'd2);
    cyc(1);
    check("bp_gap_c", 32'({slave_valid, tx_data}), 32'd2);
    master_ready = 1'b1;
    recv(b, v, -1);
    check("bp_byte1", 32'(b), 32'h5E);
    cyc(1);
    check("bp_done", 32'(tx_done), 32'd1);
    cyc(1);

    // Address wrap
    rd0 = rd_cnt;
    go(2'b11, 12'hFFF, 12'd2);
    cyc(2);
    recv(b, v, -1);
    check("w_byte0", 32'(b), 32'h81);
    cyc(1);
    recv(b, v, -1);
    check("w_byte1", 32'(b), 32'h3C);
    cyc(1);
    check("w_done", 32'(tx_done), 32'd1);
    check("w_reads", 32'(rd_cnt - rd0), 32'd2);
    check("w_addr0", 32'(rd_log[6'(rd0)]), 32'hFFF);
    check("w_addr1", 32'(rd_log[6'(rd0 + 1)]), 32'h000);
    cyc(1);

    // Non-read instruction is ignored
    rd0 = rd_cnt;
    go(2'b01, 12'h010, 12'd1);
    check("nr_busy", 32'(busy), 32'd0);
    check("nr_rden", 32'(mem_rd_en), 32'd0);
    cyc(2);
    check("nr_busy2", 32'(busy), 32'd0);
    check("nr_reads", 32'(rd_cnt - rd0), 32'd0);

    // Reset during bit 4 of byte 2
    go(2'b11, 12'h020, 12'd3);
    cyc(2);
    recv(b, v, -1);
    cyc(1);
    cyc(5);
    check("rm_bit4", 32'({slave_valid, tx_data}), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rm_valid", 32'(slave_valid), 32'd0);
    check("rm_tx", 32'(tx_data), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("rm_nodone", 32'(tx_done), 32'd0);
    cyc(1);
    check("rm_nodone2", 32'(tx_done), 32'd0);
    go(2'b11, 12'h010, 12'd1);
    cyc(2);
    recv(b, v, -1);
    check("rm_after_byte", 32'(b), 32'hB5);
    cyc(1);
    check("rm_after_done", 32'(tx_done), 32'd1);
    cyc(1);

    // Start while busy is ignored
    rd0 = rd_cnt;
    go(2'b11, 12'h030, 12'd2);
    cyc(2);
    instruction = 2'b11;
    base_addr   = 12'h100;
    burst_num   = 12'd5;
    recv(b, v, 2);
    check("sb_byte0", 32'(b), 32'hC3);
    cyc(1);
    recv(b, v, -1);
    check("sb_byte1", 32'(b), 32'h5E);
    cyc(1);
    check("sb_done", 32'(tx_done), 32'd1);
    check("sb_reads", 32'(rd_cnt - rd0), 32'd2);
    check("sb_addr1", 32'(rd_log[6'(rd0 + 1)]), 32'h031);
    cyc(1);
    check("sb_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
